// File: rtl/periph_timer.sv
// periph_timer: memory-mapped 32-bit timer/counter with compare, sticky match flag and
// interrupt. Decodes a 16-byte window, writes on the rising edge, reads combinationally.
module periph_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0004_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    input  logic [3:0]  dwe_i,
    output logic [31:0] drdata_o,
    output logic        irq_o
);

    localparam logic [1:0] OffCtrl   = 2'd0;
    localparam logic [1:0] OffCount  = 2'd1;
    localparam logic [1:0] OffCmp    = 2'd2;
    localparam logic [1:0] OffStatus = 2'd3;

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic [1:0]  offset;
    logic        ctrl_wr;
    logic        status_wr;
    logic        match_now;

    assign hit       = (daddr_i[31:4] == BASE_ADDR[31:4]);
    assign offset    = daddr_i[3:2];
    // CTRL and STATUS only react when the low byte lane is enabled.
    assign ctrl_wr   = hit && (offset == OffCtrl) && dwe_i[0];
    assign status_wr = hit && (offset == OffStatus) && dwe_i[0];
    // Compare uses the EN stored before this edge.
    assign match_now = en_q && (count_q == cmp_q);

    // Next-state for control, counter, compare, match flag and interrupt.
    always_comb begin
        en_d    = en_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q;

        if (ctrl_wr) begin
            en_d   = dwdata_i[0];
            auto_d = dwdata_i[2];
            ie_d   = dwdata_i[3];
        end

        if (ctrl_wr && dwdata_i[1]) begin
            count_d = '0;
        end else if (match_now && auto_q) begin
            count_d = '0;
        end else if (en_q) begin
            count_d = count_q + 32'd1;
        end

        if (hit && (offset == OffCmp)) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe_i[i]) begin
                    cmp_d[8*i +: 8] = dwdata_i[8*i +: 8];
                end
            end
        end

        // A set in the same edge as a write-1-to-clear wins.
        if (match_now) begin
            match_d = 1'b1;
        end else if (status_wr && dwdata_i[0]) begin
            match_d = 1'b0;
        end

        irq_d = match_d & ie_d;
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            count_q <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    // Combinational read mux; misses return zero.
    always_comb begin
        drdata_o = '0;
        if (hit) begin
            case (offset)
                OffCtrl:   drdata_o = {28'd0, ie_q, auto_q, 1'b0, en_q};
                OffCount:  drdata_o = count_q;
                OffCmp:    drdata_o = cmp_q;
                OffStatus: drdata_o = {30'd0, en_q, match_q};
                default:   drdata_o = '0;
            endcase
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_periph_timer.sv
// tb_periph_timer: table-driven register checks plus directed multi-cycle sequences.
module tb_periph_timer;

    localparam logic [31:0] ACtrl   = 32'h0004_0000;
    localparam logic [31:0] ACount  = 32'h0004_0004;
    localparam logic [31:0] ACmp    = 32'h0004_0008;
    localparam logic [31:0] AStatus = 32'h0004_000C;

    logic        clk;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic        irq;

    int total;
    int bad;

    periph_timer #(
        .BASE_ADDR(32'h0004_0000)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .daddr_i (daddr),
        .dwdata_i(dwdata),
        .dwe_i   (dwe),
        .drdata_o(drdata),
        .irq_o   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        daddr  = a;
        dwdata = d;
        dwe    = be;
        @(posedge clk);
        #1;
        dwe    = 4'd0;
        dwdata = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        daddr = a;
        #1;
        chk(name, drdata, exp);
    endtask

    task automatic chk_irq(input logic exp, input string name);
        chk(name, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        daddr  = 32'd0;
        dwdata = 32'd0;
        dwe    = 4'd0;

        // Reset values, visible combinationally.
        #2;
        rd(ACtrl, 32'h0, "rst_ctrl");
        rd(ACount, 32'h0, "rst_count");
        rd(ACmp, 32'hFFFF_FFFF, "rst_cmp");
        rd(AStatus, 32'h0, "rst_status");
        chk_irq(1'b0, "rst_irq");
        @(negedge clk);
        reset = 1'b0;

        // {write addr, write data, byte enables, read addr, expected read}
        vecs[0]  = '{ACmp, 32'hAABB_CCDD, 4'b0011, ACmp, 32'hFFFF_CCDD};
        vecs[1]  = '{32'h0004_0010, 32'h1234_5678, 4'b1111, 32'h0004_0010, 32'h0};
        vecs[2]  = '{32'h0005_0008, 32'h1234_5678, 4'b1111, ACmp, 32'hFFFF_CCDD};
        vecs[3]  = '{ACount, 32'h0000_0055, 4'b1111, ACount, 32'h0};
        vecs[4]  = '{ACtrl, 32'h0000_000F, 4'b0010, ACtrl, 32'h0};
        vecs[5]  = '{ACtrl, 32'hFFFF_FFFC, 4'b0001, ACtrl, 32'h0000_000C};
        vecs[6]  = '{ACtrl, 32'h0000_0002, 4'b0001, ACtrl, 32'h0};
        vecs[7]  = '{ACmp, 32'h1234_5678, 4'b1111, 32'h0004_000B, 32'h1234_5678};
        vecs[8]  = '{ACmp, 32'h9A00_0000, 4'b1000, ACmp, 32'h9A34_5678};
        vecs[9]  = '{ACmp, 32'h0000_0000, 4'b0000, ACmp, 32'h9A34_5678};
        vecs[10] = '{AStatus, 32'hFFFF_FFFF, 4'b1111, AStatus, 32'h0};

        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata, vecs[i].be);
            rd(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
        end
        rd(ACount, 32'h0, "vec_count_idle");

        // Auto-reload, CMP=3: 1,2,3,0 with MATCH/irq on the 3->0 edge.
        wr(ACmp, 32'd3, 4'b1111);
        wr(ACtrl, 32'h0000_000D, 4'b0001);
        rd(ACount, 32'd0, "ar_en_edge");
        tick(1); rd(ACount, 32'd1, "ar_c1");
        tick(1); rd(ACount, 32'd2, "ar_c2");
        tick(1); rd(ACount, 32'd3, "ar_c3");
        rd(AStatus, 32'h2, "ar_st_pre");
        chk_irq(1'b0, "ar_irq_pre");
        tick(1); rd(ACount, 32'd0, "ar_c0");
        rd(AStatus, 32'h3, "ar_st_post");
        chk_irq(1'b1, "ar_irq_post");
        tick(1); rd(ACount, 32'd1, "ar_c1b");

        // Plain clear, then clear on the matching edge (set wins), then clear again.
        wr(AStatus, 32'h1, 4'b0001);
        rd(AStatus, 32'h2, "clr_st");
        chk_irq(1'b0, "clr_irq");
        rd(ACount, 32'd2, "clr_cnt");
        tick(1); rd(ACount, 32'd3, "svc_c3");
        wr(AStatus, 32'h1, 4'b0001);
        rd(AStatus, 32'h3, "svc_st_setwins");
        chk_irq(1'b1, "svc_irq_setwins");
        rd(ACount, 32'd0, "svc_cnt");
        wr(AStatus, 32'h1, 4'b0001);
        rd(AStatus, 32'h2, "svc_st_cleared");
        chk_irq(1'b0, "svc_irq_cleared");

        // Free-run past CMP=5 without auto-reload or IE.
        wr(ACtrl, 32'h0, 4'b0001);
        wr(ACmp, 32'd5, 4'b1111);
        wr(ACtrl, 32'h0000_0003, 4'b0001);
        rd(ACount, 32'd0, "fr_clr_en");
        tick(5); rd(ACount, 32'd5, "fr_c5");
        rd(AStatus, 32'h2, "fr_st5");
        tick(1); rd(ACount, 32'd6, "fr_c6");
        rd(AStatus, 32'h3, "fr_st6");
        tick(2); rd(ACount, 32'd8, "fr_c8");
        chk_irq(1'b0, "fr_irq");

        // CLR with IE: MATCH stays sticky, irq follows; run to 7, then async reset.
        wr(ACtrl, 32'h0000_000B, 4'b0001);
        rd(ACount, 32'd0, "pre_rst_clr");
        chk_irq(1'b1, "pre_rst_irq_a");
        tick(7); rd(ACount, 32'd7, "pre_rst_c7");
        rd(AStatus, 32'h3, "pre_rst_st");
        chk_irq(1'b1, "pre_rst_irq_b");
        reset = 1'b1;
        #1;
        chk_irq(1'b0, "async_irq");
        rd(ACount, 32'd0, "async_count");
        rd(AStatus, 32'h0, "async_status");
        rd(ACmp, 32'hFFFF_FFFF, "async_cmp");
        rd(ACtrl, 32'h0, "async_ctrl");
        @(negedge clk);
        reset = 1'b0;

        // CMP=0 with auto-reload: COUNT pinned at 0, MATCH every enabled edge.
        wr(ACmp, 32'd0, 4'b1111);
        wr(ACtrl, 32'h0000_0005, 4'b0001);
        rd(AStatus, 32'h2, "z_st_en");
        tick(1); rd(ACount, 32'd0, "z_c0");
        rd(AStatus, 32'h3, "z_st_m");
        tick(2); rd(ACount, 32'd0, "z_c0b");
        wr(AStatus, 32'h1, 4'b0001);
        rd(AStatus, 32'h3, "z_setwins");
        wr(ACtrl, 32'h0, 4'b0001);
        rd(AStatus, 32'h1, "z_dis");
        wr(AStatus, 32'h1, 4'b0001);
        rd(AStatus, 32'h0, "z_clr");

        // CLR+EN together, then disable freezes COUNT; CMP=FFFFFFFF never matches early.
        wr(ACmp, 32'hFFFF_FFFF, 4'b1111);
        wr(ACtrl, 32'h0000_0003, 4'b0001);
        rd(ACount, 32'd0, "fz_c0");
        tick(1); rd(ACount, 32'd1, "fz_c1");
        tick(3); rd(ACount, 32'd4, "fz_c4");
        rd(AStatus, 32'h2, "fz_st_run");
        wr(ACtrl, 32'h0, 4'b0001);
        rd(ACount, 32'd5, "fz_c5");
        tick(3); rd(ACount, 32'd5, "fz_frozen");
        rd(AStatus, 32'h0, "fz_st_stop");
        chk_irq(1'b0, "fz_irq");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/periph_timer.md
# periph_timer

Memory-mapped timer/counter peripheral that sits on the peripheral branch of the bus interface unit and answers the CPU's data-bus loads and stores. It holds a free-running/auto-reload 32-bit counter, a compare register, a sticky match flag and an interrupt output. It decodes its own 16-byte window, writes registers on the clock edge and returns read data combinationally in the same cycle, matching the DMEM read model.

## Interface
- BASE_ADDR, 32'h40000, window base; must be 16-byte aligned
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- daddr  in  32  byte address from BIU (daddr2)
- dwdata  in  32  store data from BIU (dwdata2)
- dwe  in  4  per-byte write enables, bit i -> dwdata[8i+7:8i]; 0 = load/idle
- drdata  out  32  read data to BIU (drdata2), combinational
- irq  out  1  match interrupt, registered

## Operation
- Hit: daddr[31:4] == BASE_ADDR[31:4]; offset = daddr[3:2]; daddr[1:0] ignored. No hit -> no state change, drdata = 0.
- Offset 0 CTRL (R/W): bit0 EN, bit1 CLR (write-only, self-clearing, reads 0), bit2 AUTORELOAD, bit3 IE; bits 31:4 read 0. Written only when dwe[0]=1.
- Offset 1 COUNT (RO): current counter; writes ignored.
- Offset 2 CMP (R/W): compare value; byte lanes honour dwe individually.
- Offset 3 STATUS: bit0 MATCH (sticky; write 1 with dwe[0]=1 clears, write 0 no effect), bit1 RUNNING (= CTRL.EN, RO); other bits 0.
- Counter next-state priority, per edge: (1) CTRL write with CLR=1 -> 0; (2) EN=1 and COUNT==CMP and AUTORELOAD=1 -> 0; (3) EN=1 -> COUNT+1, modulo 2^32 (0xFFFFFFFF wraps to 0, no flag); (4) hold.
- EN used in the compare/increment is the value stored before the edge; a CTRL write takes effect from the following edge.
- MATCH set at any edge where EN=1 and COUNT==CMP, regardless of AUTORELOAD; without AUTORELOAD counting continues past CMP.
- Set-vs-clear: MATCH set in the same edge as a write-1-to-clear -> MATCH remains 1 (set wins).
- irq register <= next MATCH & next IE, i.e. irq follows MATCH and IE with the same edge.

## Timing
- Reset values: CTRL=0, COUNT=0, CMP=32'hFFFFFFFF, MATCH=0, irq=0; drdata reflects these combinationally (e.g. CMP reads 32'hFFFFFFFF).
- Reset asserted mid-count: all registers clear immediately without waiting for clk; irq drops in the same cycle.
- Writes: committed at the rising edge where dwe!=0 and hit; readable at the next cycle.
- Reads: zero latency; drdata valid in the same cycle as daddr, no handshake, no wait states.
- Enable at edge N (EN written 1) -> COUNT=1 after edge N+1.
- AUTORELOAD period = CMP+1 cycles; MATCH/irq rise at the edge where COUNT goes CMP->0.
- CMP=0 with AUTORELOAD: COUNT stays 0, MATCH set every edge while EN=1.
- CLR and EN=1 in one write: COUNT->0 at that edge, increments from the next.
- Disabling (EN=0) freezes COUNT; MATCH keeps its value.

## Test plan
- Reset: assert reset mid-run with COUNT=7, MATCH=1 -> immediately COUNT=0, MATCH=0, irq=0, read CMP=32'hFFFFFFFF.
- Auto-reload: CMP=3, CTRL=4'b1101 -> COUNT sequence 1,2,3,0,1,...; MATCH and irq rise on the 3->0 edge; STATUS reads 32'h3.
- Free-run wrap: CMP=5, CTRL=4'b0001, run 8 cycles -> COUNT reaches 8, MATCH=1 set at count 5, irq=0 (IE=0).
- Wrap-around: force via CLR then CMP=32'hFFFFFFFF with EN, plus long run from preloaded timing -> 0xFFFFFFFF -> 0, MATCH set once at 0xFFFFFFFF, not at 0.
- Set-vs-clear: write STATUS=1 on the exact edge COUNT==CMP -> MATCH stays 1; write again next cycle -> MATCH=0, irq=0.
- Decode/byte lanes: store to 32'h40010 -> no change, load returns 0; store 32'hAABBCCDD to CMP with dwe=4'b0011 -> CMP=32'hFFFFCCDD; store to COUNT -> ignored.
